muldiv_seq: RTL and testbench

//  Multi-cycle signed multiply/divide sequencer owning the HI/LO register pair.

---
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_seq.sv | 167 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide sequencer.
// EX is the master; the sequencer is the slave.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             read_hilo;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, A, B, read_hilo,
    input  HI, LO, busy, done, stall
  );

  modport slave (
    input  start, op, A, B, read_hilo,
    output HI, LO, busy, done, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply/divide sequencer owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fixed at the end.
//
// state  | meaning
// S_IDLE | waiting for MULT/DIV; HI/LO hold last result
// S_PREP | take magnitudes and signs of captured operands
// S_RUN  | WIDTH iterations of shift-add or shift-subtract
// S_FIX  | apply signs, HI/LO written on exit
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_MULT = 4'hA;
  localparam logic [3:0] OP_DIV  = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_valid, accept, busy;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_valid = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign accept   = bus.start && op_valid && (state_q == S_IDLE);

  assign a_abs    = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_abs    = b_q[WIDTH-1] ? -b_q : b_q;

  // acc/rem carry one extra bit so the add carry and the trial-subtract compare are exact
  assign mul_sum  = acc_q + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh   = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};

  assign prod_mag = {acc_q[WIDTH-1:0], work_q};
  assign prod     = neg_res_q ? -prod_mag : prod_mag;
  assign quo_fix  = neg_res_q ? -work_q : work_q;
  assign rem_fix  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    bus.busy  = busy;
    bus.stall = busy && ((bus.start && op_valid) || bus.read_hilo);
    bus.done  = done_q;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_PREP;
      S_PREP:  state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = bus.A;
          b_d      = bus.B;
          is_div_d = (bus.op == OP_DIV);
        end
      end
      S_PREP: begin
        opnd_d    = is_div_q ? b_abs : a_abs;
        work_d    = is_div_q ? a_abs : b_abs;
        acc_d     = '0;
        neg_res_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        neg_rem_d = is_div_q & a_q[WIDTH-1];
        cnt_d     = '0;
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!is_div_q) begin
          acc_d  = {1'b0, mul_sum[WIDTH:1]};
          work_d = {mul_sum[0], work_q[WIDTH-1:1]};
        end else if (rem_ge) begin
          acc_d  = rem_sh - {1'b0, opnd_q};
          work_d = {work_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = rem_sh;
          work_d = {work_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          // most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      acc_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: transaction-level reference model compared every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from signed arithmetic
  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q, r;
    if (op == 4'hA) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // Model: remaining busy cycles plus pending result
  int          m_left;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_done;
  logic        exp_busy, exp_stall, in_valid;

  assign in_valid  = (bus.op == 4'hA) || (bus.op == 4'hB);
  assign exp_busy  = (m_left != 0);
  assign exp_stall = exp_busy && ((bus.start && in_valid) || bus.read_hilo);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= r_hi;
          m_lo   <= r_lo;
          m_done <= 1'b1;
        end
      end else if (bus.start && in_valid) begin
        {r_hi, r_lo} <= ref_op(bus.op, bus.A, bus.B);
        m_left       <= W + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  {31'b0, bus.busy},  {31'b0, exp_busy});
      chk("cyc_done",  {31'b0, bus.done},  {31'b0, m_done});
      chk("cyc_stall", {31'b0, bus.stall}, {31'b0, exp_stall});
      chk("cyc_hi",    bus.HI, m_hi);
      chk("cyc_lo",    bus.LO, m_lo);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  // Counts stall cycles until done; returns at the negedge of the done cycle
  task automatic count_stall_to_done(input string nm, output int cnt);
    bit seen;
    seen = 0;
    cnt  = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.stall) cnt++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, cnt;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 4'h0; bus.A = '0; bus.B = '0; bus.read_hilo = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_hi",   bus.HI, 32'h0);
    chk("rst_lo",   bus.LO, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // MULT 7 * -3
    issue(4'hA, 32'd7, 32'hFFFFFFFD);
    wait_done("mult1", cyc);
    chk("mult1_latency", 32'(cyc), 32'd35);
    chk("mult1_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult1_lo", bus.LO, 32'hFFFFFFEB);

    // DIV -7 / 2, 7 / -2
    issue(4'hB, 32'hFFFFFFF9, 32'd2);
    wait_done("div1", cyc);
    chk("div1_lo", bus.LO, 32'hFFFFFFFD);
    chk("div1_hi", bus.HI, 32'hFFFFFFFF);
    issue(4'hB, 32'd7, 32'hFFFFFFFE);
    wait_done("div2", cyc);
    chk("div2_lo", bus.LO, 32'hFFFFFFFD);
    chk("div2_hi", bus.HI, 32'd1);

    // divide by zero, overflow
    issue(4'hB, 32'd5, 32'd0);
    wait_done("divz", cyc);
    chk("divz_latency", 32'(cyc), 32'd35);
    chk("divz_hi", bus.HI, 32'd5);
    chk("divz_lo", bus.LO, 32'hFFFFFFFF);
    issue(4'hB, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divov", cyc);
    chk("divov_lo", bus.LO, 32'h80000000);
    chk("divov_hi", bus.HI, 32'h0);

    // ignored op code
    issue(4'h3, 32'd9, 32'd9);
    @(negedge clk);
    chk("badop_busy", {31'b0, bus.busy}, 32'h0);

    // read_hilo from cycle 5 of a MULT
    issue(4'hA, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1 bus.read_hilo = 1'b1;
    count_stall_to_done("rdhl", cnt);
    chk("rdhl_stall_cycles", 32'(cnt), 32'd30);
    chk("rdhl_done_stall", {31'b0, bus.stall}, 32'h0);
    chk("rdhl_lo", bus.LO, 32'd12);
    chk("rdhl_hi", bus.HI, 32'd0);
    @(posedge clk); #1 bus.read_hilo = 1'b0;

    // back-to-back MULT then DIV with start held
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 4'hA; bus.A = 32'd6; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.op = 4'hB; bus.A = 32'd100; bus.B = 32'hFFFFFFF9;
    count_stall_to_done("b2b_mult", cnt);
    chk("b2b_stall_cycles", 32'(cnt), 32'd34);
    chk("b2b_mult_lo", bus.LO, 32'd42);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("b2b_div", cyc);
    chk("b2b_div_latency", 32'(cyc), 32'd35);
    chk("b2b_div_lo", bus.LO, 32'hFFFFFFF2);
    chk("b2b_div_hi", bus.HI, 32'd2);

    // reset at cycle 10 of a MULT
    issue(4'hA, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_hi",   bus.HI, 32'h0);
    chk("abort_lo",   bus.LO, 32'h0);
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(4'hA, 32'd2, 32'd2);
    wait_done("post_rst", cyc);
    chk("post_rst_lo", bus.LO, 32'd4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.read_hilo = ($urandom_range(0, 3) == 0);
      if (bus.start) begin
        case ($urandom_range(0, 9))
          0:             bus.op = 4'h3;
          1, 2, 3, 4:    bus.op = 4'hA;
          default:       bus.op = 4'hB;
        endcase
        bus.A = rnd_opnd();
        bus.B = rnd_opnd();
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.read_hilo = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
